// File: rtl/video_dram_rd_arb_if.sv
// Requester/controller bundle for the video DRAM read arbiter.
// master = requesters + memory controller side, slave = arbiter.
interface video_dram_rd_arb_if #(
  parameter int NREQ = 3,
  parameter int AW   = 21
);
  logic               flush;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    next;
  logic [NREQ-1:0]    grant;
  logic               dram_req;
  logic [AW-1:0]      dram_addr;
  logic               dram_next;
  logic               busy;

  modport master (output flush, req, addr, dram_next,
                  input  next, grant, dram_req, dram_addr, busy);
  modport slave  (input  flush, req, addr, dram_next,
                  output next, grant, dram_req, dram_addr, busy);
endinterface

// File: rtl/video_dram_rd_arb.sv
// Round-robin read arbiter sharing one video DRAM read port among NREQ
// requesters, with a per-grant word cap so no requester starves the others.
module video_dram_rd_arb #(
  parameter int NREQ  = 3,
  parameter int AW    = 21,
  parameter int BURST = 8
) (
  input logic                clk,
  input logic                rst,
  video_dram_rd_arb_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   ptr_q,   ptr_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  logic            win_vld;
  logic [PW-1:0]   win_idx;
  logic            own_req;
  logic [AW-1:0]   addr_mux;

  // Cyclic search from ptr; descending k so the smallest offset wins last.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (bus.req[idx]) begin
        win_vld = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    addr_mux = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant_q[i]) addr_mux = addr_mux | bus.addr[i*AW +: AW];
  end

  assign own_req       = |(bus.req & grant_q);
  assign bus.dram_req  = own_req;
  assign bus.dram_addr = addr_mux;
  assign bus.next      = bus.dram_next ? grant_q : '0;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == GRANT);

  always_comb begin
    logic arb;
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    arb     = 1'b0;

    case (state_q)
      IDLE:  arb = 1'b1;
      GRANT: begin
        if (!own_req) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (bus.dram_next) begin
          if (cnt_q == CW'(BURST - 1)) arb = 1'b1;
          else                         cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    // Burst end re-arbitrates in the same cycle, so back-to-back grants have no bubble.
    if (arb) begin
      if (win_vld) begin
        state_d = GRANT;
        grant_d = NREQ'(1) << win_idx;
        ptr_d   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end

    if (bus.flush) begin
      state_d = IDLE;
      grant_d = '0;
      cnt_d   = '0;
      ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_video_dram_rd_arb.sv
// Directed bench for video_dram_rd_arb: BURST=8 main instance plus a BURST=1 instance.
module tb_video_dram_rd_arb;
  localparam int NREQ = 3;
  localparam int AW   = 21;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;
  logic [AW-1:0] adr [NREQ];

  video_dram_rd_arb_if #(.NREQ(NREQ), .AW(AW)) bus0 ();
  video_dram_rd_arb_if #(.NREQ(NREQ), .AW(AW)) bus1 ();

  video_dram_rd_arb #(.NREQ(NREQ), .AW(AW), .BURST(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  video_dram_rd_arb #(.NREQ(NREQ), .AW(AW), .BURST(1)) dut_b1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  always_comb bus0.addr = {adr[2], adr[1], adr[0]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One clock; requesters advance their address on their own next strobe.
  task automatic tick();
    logic [NREQ-1:0] n;
    n = bus0.next;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (n[i]) adr[i] = adr[i] + 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus0.req = '0; bus0.flush = 1'b0; bus0.dram_next = 1'b0;
    bus1.req = '0; bus1.flush = 1'b0; bus1.dram_next = 1'b0;
    for (int i = 0; i < NREQ; i++) adr[i] = '0;
    @(negedge clk);
    #1;
    chk("rst_grant", 32'(bus0.grant), 0);
    chk("rst_dram_req", 32'(bus0.dram_req), 0);
    chk("rst_busy", 32'(bus0.busy), 0);
    chk("rst_dram_addr", 32'(bus0.dram_addr), 0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    bus1.addr = '0;

    // Single requester, continuous stream across the burst boundary
    do_reset();
    adr[0] = 21'h1000;
    bus0.req = 3'b001;
    #1;
    chk("t1_req_lat0", 32'(bus0.dram_req), 0);
    tick();
    chk("t1_req_lat1", 32'(bus0.dram_req), 1);
    chk("t1_grant", 32'(bus0.grant), 32'b001);
    bus0.dram_next = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("t1_addr%0d", k), 32'(bus0.dram_addr), 32'h1000 + k);
      chk($sformatf("t1_next%0d", k), 32'(bus0.next), 32'b001);
      chk($sformatf("t1_dreq%0d", k), 32'(bus0.dram_req), 1);
      tick();
    end
    bus0.dram_next = 1'b0;
    bus0.req = '0;
    tick();
    chk("t1_idle_busy", 32'(bus0.busy), 0);

    // All three requesting, round-robin with no idle cycles
    do_reset();
    bus0.req = 3'b111;
    tick();
    bus0.dram_next = 1'b1;
    for (int w = 0; w < 25; w++) begin
      chk($sformatf("t2_grant%0d", w), 32'(bus0.grant), 32'(1 << ((w / 8) % 3)));
      chk($sformatf("t2_dreq%0d", w), 32'(bus0.dram_req), 1);
      tick();
    end
    bus0.dram_next = 1'b0;

    // Owner 1 drops req mid-burst while req0 is held
    do_reset();
    bus0.req = 3'b010;
    tick();
    chk("t3_grant1", 32'(bus0.grant), 32'b010);
    bus0.req = 3'b011;
    bus0.dram_next = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t3_next%0d", k), 32'(bus0.next), 32'b010);
      tick();
    end
    bus0.req = 3'b001;
    bus0.dram_next = 1'b0;
    #1;
    chk("t3_drop_dreq", 32'(bus0.dram_req), 0);
    tick();
    chk("t3_after_grant", 32'(bus0.grant), 0);
    chk("t3_after_dreq", 32'(bus0.dram_req), 0);
    chk("t3_after_addr", 32'(bus0.dram_addr), 0);
    tick();
    chk("t3_regrant", 32'(bus0.grant), 32'b001);

    // flush mid-burst with a word in the same cycle
    do_reset();
    bus0.req = 3'b011;
    tick();
    bus0.dram_next = 1'b1;
    tick();
    chk("t4_grant", 32'(bus0.grant), 32'b001);
    tick();
    bus0.flush = 1'b1;
    #1;
    chk("t4_flush_next", 32'(bus0.next), 32'b001);
    tick();
    bus0.flush = 1'b0;
    #1;
    chk("t4_post_grant", 32'(bus0.grant), 0);
    chk("t4_post_busy", 32'(bus0.busy), 0);
    chk("t4_post_next", 32'(bus0.next), 0);
    tick();
    chk("t4_regrant", 32'(bus0.grant), 32'b001);
    bus0.dram_next = 1'b0;

    // Asynchronous reset between edges; ptr must restart at 0
    do_reset();
    bus0.req = 3'b010;
    tick();
    bus0.dram_next = 1'b1;
    tick();
    chk("t5_grant_pre", 32'(bus0.grant), 32'b010);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_async_grant", 32'(bus0.grant), 0);
    chk("t5_async_dreq", 32'(bus0.dram_req), 0);
    chk("t5_async_next", 32'(bus0.next), 0);
    chk("t5_async_busy", 32'(bus0.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    bus0.req = 3'b111;
    bus0.dram_next = 1'b0;
    #1;
    tick();
    chk("t5_restart", 32'(bus0.grant), 32'b001);

    // BURST=1 alternates on every word
    do_reset();
    bus1.req = 3'b101;
    tick();
    bus1.dram_next = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t6_grant%0d", k), 32'(bus1.grant), (k % 2) ? 32'b100 : 32'b001);
      chk($sformatf("t6_next%0d", k), 32'(bus1.next), (k % 2) ? 32'b100 : 32'b001);
      tick();
    end
    bus1.dram_next = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/video_dram_rd_arb.md
Name: video_dram_rd_arb

Overview:
- Read-side arbiter sharing one video DRAM read port among NREQ video requesters: TS tilemap prefetch, TS renderer graphics fetch, and a spare/bitmap fetcher.
- Each requester uses the TS-unit style interface: hold req with a word address; receive a per-word next strobe, with data valid in that cycle.
- Grants are round-robin with a per-grant burst cap, so no requester can starve the others within a line.
- Sits between the video TS/renderer blocks and the memory controller's video read channel.

Parameters:
- NREQ, 3: number of requesters, 2..4. Index 0 = tilemap prefetch, 1 = TS renderer, 2 = spare.
- AW, 21: DRAM word-address width.
- BURST, 8: maximum words per grant, 1..64.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort, pulsed at video line start.
- req  in  NREQ  per-requester read request, held while words are wanted.
- addr  in  NREQ*AW  per-requester word address; slice i is bits [i*AW +: AW].
- next  out  NREQ  per-requester word strobe; next[i] = dram_next & grant[i].
- grant  out  NREQ  registered one-hot current owner; 0 when idle.
- dram_req  out  1  request to the memory controller.
- dram_addr  out  AW  address to the memory controller.
- dram_next  in  1  controller accepted/returned one word this cycle.
- busy  out  1  state == GRANT.

Behaviour:
- Reset (async): state=IDLE, grant=0, ptr=0, cnt=0. Outputs: dram_req=0, next=0, busy=0, dram_addr=0.
- States: IDLE and GRANT.
  - ptr is a round-robin pointer, width clog2(NREQ).
  - cnt counts words in the current grant, width clog2(BURST)+1.
- Arbitration function, used in IDLE and at grant end:
  - Search req cyclically, starting at index ptr.
  - The first asserted index w is the winner.
  - On winning: grant<=onehot(w), ptr<=(w+1) mod NREQ, cnt<=0, state<=GRANT.
  - If no req is asserted: grant<=0, state<=IDLE.
- IDLE: evaluate the arbitration function every cycle. Latency from req rising to dram_req high is 1 cycle.
- GRANT, owner o:
  - dram_req = req[o] (combinational).
  - dram_addr = addr slice o (combinational).
  - next[o] = dram_next; all other next bits are 0.
- Grant end conditions, evaluated each GRANT cycle:
  - (a) req[o]==0: state<=IDLE, grant<=0, with no re-arbitration that cycle. A dram_next in such a cycle is ignored; the controller must not issue it.
  - (b) dram_next && cnt==BURST-1: re-arbitrate in the same cycle (a back-to-back grant with no bubble). The current owner competes at lowest priority because ptr has already moved past it.
  - Otherwise: on dram_next, cnt<=cnt+1.
- dram_addr when IDLE: 0. dram_addr may change in any cycle without dram_next, because the requester advances its address only on its own next.
- flush overrides everything in the same edge: state<=IDLE, grant<=0, cnt<=0, ptr<=0. A dram_next in the flush cycle is still routed to the current owner (combinational), so the word is not lost.
- BURST==1: every dram_next ends the grant and re-arbitrates.
- Single requester continuously asserted: re-granted after each burst, so dram_req never drops.
- Starvation bound: a requester held asserted waits at most (NREQ-1)*BURST words plus 1 cycle.
- grant is always zero or one-hot; grant, req and next never reference an index >= NREQ.

Test Plan:
- Reset, then req=3'b001 with addr0=0x1000; requester 0 increments its address on next; dram_next held 1 for 10 cycles:
  - dram_req rises 1 cycle after req.
  - dram_addr = 0x1000..0x1007, then 0x1008 continues without a bubble.
  - next=3'b001 on every strobe.
- req=3'b111 held, dram_next constant 1, BURST=8, ptr=0 after reset:
  - grant sequence 001 (8 words), 010 (8), 100 (8), 001.
  - Each transition has zero idle cycles.
- Owner 1 drops req after 3 words while req0 is held:
  - cycle after the drop: grant=0, dram_req=0;
  - next cycle: grant=001 (ptr=2, searching 2,0 gives 0).
- flush pulsed mid-burst with dram_next=1 in the same cycle:
  - that word's next reaches the old owner.
  - Next cycle: grant=0, busy=0.
  - Then grant goes to the lowest asserted index (ptr=0).
- rst asserted asynchronously mid-grant, between clock edges:
  - grant, dram_req, next and busy go to 0 immediately.
  - After release, arbitration restarts from ptr=0.
- BURST=1 with req=3'b101 and dram_next=1 every cycle: grant alternates 001, 100, 001 on every word.
